// File: rtl/sc_note_feeder.sv
// rtl/sc_note_feeder.sv - note timestamp prefetcher between the song note ROM and the note matcher
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         pulse: abort current activity, restart the song from entry 0
//   note_request  pulse from matcher: consume the current note, fetch the next
//   rom_addr      registered note ROM read address
//   rom_data      note ROM read data, valid ROM_LATENCY cycles after rom_addr changes
//   note_time     current note timestamp, stable while note_valid is high
//   note_valid    note_time holds a valid, unconsumed note
//   song_done     terminator or end of memory reached; level until start or reset
//   req_overflow  one-cycle pulse when a request is dropped

module sc_note_feeder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int TIME_WIDTH  = 16,
  parameter int ROM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  note_request,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [TIME_WIDTH-1:0] rom_data,
  output logic [TIME_WIDTH-1:0] note_time,
  output logic                  note_valid,
  output logic                  song_done,
  output logic                  req_overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_READY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0]            LAT      = 3'(ROM_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic [2:0]              wait_cnt, wait_cnt_nxt;
  logic                    pending, pending_nxt;
  logic [ADDR_WIDTH-1:0]   rom_addr_nxt;
  logic [TIME_WIDTH-1:0]   note_time_nxt;
  logic                    note_valid_nxt;
  logic                    song_done_nxt;
  logic                    req_overflow_nxt;

  logic landing;   // the ROM word for rom_addr is on rom_data this cycle
  logic is_term;   // all-ones word marks the end of the song
  logic at_last;   // no further entry exists; advancing would wrap
  logic consume;   // a request (fresh or pending) is served in READY

  assign landing = (state == S_FETCH) && (wait_cnt <= 3'd1);
  assign is_term = &rom_data;
  assign at_last = &rom_addr;
  assign consume = (state == S_READY) && (note_request || pending);

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wait_cnt     <= 3'd0;
      pending      <= 1'b0;
      rom_addr     <= '0;
      note_time    <= '0;
      note_valid   <= 1'b0;
      song_done    <= 1'b0;
      req_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      pending      <= pending_nxt;
      rom_addr     <= rom_addr_nxt;
      note_time    <= note_time_nxt;
      note_valid   <= note_valid_nxt;
      song_done    <= song_done_nxt;
      req_overflow <= req_overflow_nxt;
    end
  end

  // Next-state logic; start overrides everything, including a same-cycle request
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_FETCH;
    end else begin
      case (state)
        S_FETCH: if (landing) state_nxt = is_term ? S_DONE : S_READY;
        S_READY: if (consume) state_nxt = at_last ? S_DONE : S_FETCH;
        default: state_nxt = state;
      endcase
    end
  end

  // Next values of the counter, pending flag and registered outputs
  always_comb begin
    wait_cnt_nxt     = wait_cnt;
    pending_nxt      = pending;
    rom_addr_nxt     = rom_addr;
    note_time_nxt    = note_time;
    note_valid_nxt   = note_valid;
    song_done_nxt    = song_done;
    req_overflow_nxt = 1'b0;

    if (start) begin
      rom_addr_nxt   = '0;
      wait_cnt_nxt   = LAT;
      pending_nxt    = 1'b0;
      note_valid_nxt = 1'b0;
      song_done_nxt  = 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          // Requests during a fetch queue one deep; a second one is dropped.
          // The landing edge still counts as FETCH for this purpose.
          if (note_request) begin
            if (pending) req_overflow_nxt = 1'b1;
            else         pending_nxt      = 1'b1;
          end
          if (landing) begin
            wait_cnt_nxt = 3'd0;
            if (is_term) begin
              song_done_nxt = 1'b1;
              pending_nxt   = 1'b0;
            end else begin
              note_time_nxt  = rom_data;
              note_valid_nxt = 1'b1;
            end
          end else begin
            wait_cnt_nxt = wait_cnt - 3'd1;
          end
        end
        S_READY: begin
          if (consume) begin
            note_valid_nxt = 1'b0;
            // Serving a pending request while a fresh one arrives: the fresh
            // one becomes the new pending request for the next note.
            pending_nxt = pending && note_request;
            if (at_last) begin
              song_done_nxt = 1'b1;
              pending_nxt   = 1'b0;
            end else begin
              rom_addr_nxt = rom_addr + ADDR_ONE;
              wait_cnt_nxt = LAT;
            end
          end
        end
        default: begin
          // IDLE and DONE ignore requests entirely
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_note_feeder.sv
// tb/tb_sc_note_feeder.sv - bench for sc_note_feeder: directed song scenarios plus random stimulus against a reference model
`timescale 1ns/1ps

module tb_sc_note_feeder;

  localparam int AW0 = 10;
  localparam int L0  = 2;
  localparam int AW1 = 2;
  localparam int L1  = 3;
  localparam int TW  = 16;
  localparam logic [TW-1:0] TERM = 16'hFFFF;

  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_READY = 2;
  localparam int P_DONE  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start0 = 1'b0, req0 = 1'b0, start1 = 1'b0, req1 = 1'b0;

  logic [AW0-1:0] rom_addr0;
  logic [TW-1:0]  rom_data0, note_time0;
  logic           note_valid0, song_done0, req_overflow0;
  logic [AW1-1:0] rom_addr1;
  logic [TW-1:0]  rom_data1, note_time1;
  logic           note_valid1, song_done1, req_overflow1;

  sc_note_feeder #(.ADDR_WIDTH(AW0), .TIME_WIDTH(TW), .ROM_LATENCY(L0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .note_request(req0),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .note_time(note_time0),
    .note_valid(note_valid0), .song_done(song_done0), .req_overflow(req_overflow0)
  );

  sc_note_feeder #(.ADDR_WIDTH(AW1), .TIME_WIDTH(TW), .ROM_LATENCY(L1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .note_request(req1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .note_time(note_time1),
    .note_valid(note_valid1), .song_done(song_done1), .req_overflow(req_overflow1)
  );

  // Song ROMs: data reflects the address that was on rom_addr L cycles earlier
  logic [TW-1:0]  mem0 [0:1023];
  logic [TW-1:0]  mem1 [0:3];
  logic [AW0-1:0] h0 [1:7];
  logic [AW1-1:0] h1 [1:7];

  always @(posedge clk) begin
    h0[1] <= rom_addr0;
    h1[1] <= rom_addr1;
    for (int i = 2; i < 8; i++) begin
      h0[i] <= h0[i-1];
      h1[i] <= h1[i-1];
    end
  end

  assign rom_data0 = mem0[h0[L0-1]];
  assign rom_data1 = mem1[h1[L1-1]];

  // Reference model: landing is scheduled at an absolute cycle, data read straight from the song array
  int          cyc = 0;
  int          m_ph    [2];
  int          m_addr  [2];
  int          m_land  [2];
  bit          m_pend  [2];
  bit          m_valid [2];
  bit          m_done  [2];
  bit          m_ovf   [2];
  logic [TW-1:0] m_time [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat(input int u);
    return (u == 0) ? L0 : L1;
  endfunction

  function automatic int last_addr(input int u);
    return (u == 0) ? 1023 : 3;
  endfunction

  function automatic logic [TW-1:0] song_word(input int u, input int a);
    return (u == 0) ? mem0[a] : mem1[a];
  endfunction

  task automatic model_reset(input int u);
    m_ph[u] = P_IDLE; m_addr[u] = 0; m_land[u] = 0; m_pend[u] = 0;
    m_valid[u] = 0; m_done[u] = 0; m_ovf[u] = 0; m_time[u] = '0;
  endtask

  task automatic model_step(input int u, input bit s, input bit r);
    logic [TW-1:0] d;
    m_ovf[u] = 0;
    if (s) begin
      m_ph[u] = P_FETCH; m_addr[u] = 0; m_land[u] = cyc + lat(u);
      m_pend[u] = 0; m_valid[u] = 0; m_done[u] = 0;
    end else if (m_ph[u] == P_FETCH) begin
      if (r) begin
        if (m_pend[u]) m_ovf[u] = 1;
        else           m_pend[u] = 1;
      end
      if (cyc == m_land[u]) begin
        d = song_word(u, m_addr[u]);
        if (d == TERM) begin
          m_ph[u] = P_DONE; m_done[u] = 1; m_pend[u] = 0;
        end else begin
          m_ph[u] = P_READY; m_time[u] = d; m_valid[u] = 1;
        end
      end
    end else if (m_ph[u] == P_READY && (r || m_pend[u])) begin
      m_valid[u] = 0;
      m_pend[u]  = m_pend[u] && r;
      if (m_addr[u] == last_addr(u)) begin
        m_ph[u] = P_DONE; m_done[u] = 1; m_pend[u] = 0;
      end else begin
        m_addr[u] = m_addr[u] + 1; m_land[u] = cyc + lat(u); m_ph[u] = P_FETCH;
      end
    end
  endtask

  task automatic compare_all();
    chk("u0.rom_addr",     32'(rom_addr0),     32'(m_addr[0]));
    chk("u0.note_time",    32'(note_time0),    32'(m_time[0]));
    chk("u0.note_valid",   32'(note_valid0),   32'(m_valid[0]));
    chk("u0.song_done",    32'(song_done0),    32'(m_done[0]));
    chk("u0.req_overflow", 32'(req_overflow0), 32'(m_ovf[0]));
    chk("u1.rom_addr",     32'(rom_addr1),     32'(m_addr[1]));
    chk("u1.note_time",    32'(note_time1),    32'(m_time[1]));
    chk("u1.note_valid",   32'(note_valid1),   32'(m_valid[1]));
    chk("u1.song_done",    32'(song_done1),    32'(m_done[1]));
    chk("u1.req_overflow", 32'(req_overflow1), 32'(m_ovf[1]));
  endtask

  // Called at a negedge: drive inputs, take one rising edge, then check at the next negedge
  task automatic tick(input bit s0, input bit r0, input bit s1, input bit r1);
    start0 = s0; req0 = r0; start1 = s1; req1 = r1;
    @(posedge clk);
    cyc++;
    model_step(0, s0, r0);
    model_step(1, s1, r1);
    @(negedge clk);
    start0 = 1'b0; req0 = 1'b0; start1 = 1'b0; req1 = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem0[i] = '0;
    mem0[0] = 16'd50; mem0[1] = 16'd120; mem0[2] = 16'd300; mem0[3] = TERM;
    mem1[0] = 16'd5;  mem1[1] = 16'd6;   mem1[2] = 16'd7;   mem1[3] = 16'd8;
    model_reset(0);
    model_reset(1);

    // Reset state
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    idle(3);

    // First note after start
    tick(1, 0, 0, 0);
    chk("plan.start_addr", 32'(rom_addr0), 32'd0);
    tick(0, 0, 0, 0);
    chk("plan.not_yet_valid", 32'(note_valid0), 32'd0);
    tick(0, 0, 0, 0);
    chk("plan.first_valid", 32'(note_valid0), 32'd1);
    chk("plan.first_time", 32'(note_time0), 32'd50);
    idle(3);

    // Sequential requests
    tick(0, 1, 0, 0);
    chk("plan.req_clears_valid", 32'(note_valid0), 32'd0);
    chk("plan.req_addr", 32'(rom_addr0), 32'd1);
    idle(2);
    chk("plan.second_time", 32'(note_time0), 32'd120);
    chk("plan.second_valid", 32'(note_valid0), 32'd1);
    idle(3);
    tick(0, 1, 0, 0);
    idle(2);
    chk("plan.third_time", 32'(note_time0), 32'd300);
    idle(3);
    tick(0, 1, 0, 0);
    idle(2);
    chk("plan.term_done", 32'(song_done0), 32'd1);
    chk("plan.term_not_valid", 32'(note_valid0), 32'd0);
    tick(0, 1, 0, 0);
    chk("plan.done_ignores_req", 32'(req_overflow0), 32'd0);

    // Pending and overflow
    tick(1, 0, 0, 0);
    idle(2);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk("plan.overflow_pulse", 32'(req_overflow0), 32'd1);
    chk("plan.pending_land_valid", 32'(note_valid0), 32'd1);
    chk("plan.pending_land_time", 32'(note_time0), 32'd120);
    tick(0, 0, 0, 0);
    chk("plan.pending_served_addr", 32'(rom_addr0), 32'd2);
    chk("plan.pending_one_cycle", 32'(note_valid0), 32'd0);
    chk("plan.overflow_one_cycle", 32'(req_overflow0), 32'd0);
    idle(2);
    chk("plan.after_pending_time", 32'(note_time0), 32'd300);
    chk("plan.after_pending_valid", 32'(note_valid0), 32'd1);

    // Restart in the middle of a fetch
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("plan.restart_addr", 32'(rom_addr0), 32'd0);
    idle(2);
    chk("plan.restart_time", 32'(note_time0), 32'd50);
    chk("plan.restart_valid", 32'(note_valid0), 32'd1);

    // End of memory on the 4-entry instance, no wrap-around
    tick(0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 8 && !note_valid1; w++) tick(0, 0, 0, 0);
      chk("eom.note_ready", 32'(note_valid1), 32'd1);
      chk("eom.note_time", 32'(note_time1), 32'(5 + k));
      tick(0, 0, 0, 1);
    end
    chk("eom.song_done", 32'(song_done1), 32'd1);
    chk("eom.addr_held", 32'(rom_addr1), 32'd3);
    idle(3);
    chk("eom.addr_no_wrap", 32'(rom_addr1), 32'd3);

    // Asynchronous reset while READY
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    chk("rst.addr", 32'(rom_addr0), 32'd0);
    chk("rst.time", 32'(note_time0), 32'd0);
    chk("rst.valid", 32'(note_valid0), 32'd0);
    chk("rst.done", 32'(song_done1), 32'd0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 1);
    chk("rst.ignore_valid", 32'(note_valid0), 32'd0);
    chk("rst.ignore_overflow", 32'(req_overflow0), 32'd0);

    // Random songs and random start/request traffic
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++)
      mem0[i] = ($urandom_range(0, 31) == 0) ? TERM : 16'($urandom_range(0, 16'hFFFE));
    for (int i = 0; i < 4; i++)
      mem1[i] = ($urandom_range(0, 7) == 0) ? TERM : 16'($urandom_range(0, 16'hFFFE));
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 35);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
